// File: rtl/step_ctrl_pkg.sv
// Shared encodings for step_ctrl: mode input codes, FSM states and the mode decode.
package step_ctrl_pkg;

  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } state_t;

  // The reserved code 2'b11 falls through to HALT.
  function automatic state_t mode_to_state(input logic [1:0] mode);
    case (mode)
      MODE_RUN:  return ST_RUN;
      MODE_STEP: return ST_STEP;
      default:   return ST_HALT;
    endcase
  endfunction

endpackage

// File: rtl/step_ctrl_edge_sync.sv
// edge_sync: SYNC_STAGES-deep synchronizer followed by a registered rising-edge detector.
// Everything resets to 1 so a level that is already high at reset release gives no edge.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   rise_q, rise_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
    prev_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/step_ctrl.sv
// step_ctrl: turns slow-clock rising edges (RUN) or step-button presses (STEP) into
// single-cycle CPU enables, with a one-deep pending buffer. Macro STEP_CTRL_CNT_SAT_EN
// makes pulse_cnt saturate instead of wrap. rst_n is synchronous and active-high.
//
// state   | meaning
// ST_HALT | no events; pending buffer is flushed
// ST_RUN  | slow_in rising edges are events
// ST_STEP | step_btn rising edges are events
module step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 slow_in,
  input  logic                 step_btn,
  input  logic [1:0]           mode,
  input  logic                 stall,
  output logic                 en_out,
  output logic                 pending,
  output logic                 dropped,
  output logic [CNT_WIDTH-1:0] pulse_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  state_t               state_q, state_d;
  logic                 en_q, en_d;
  logic                 pend_q, pend_d;
  logic                 drop_q, drop_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 slow_rise, step_rise;
  logic                 event_hit;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_slow_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_in  (slow_in),
    .rise  (slow_rise)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_step_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_in  (step_btn),
    .rise  (step_rise)
  );

  always_comb begin
    state_d   = mode_to_state(mode);
    event_hit = ((state_q == ST_RUN) && slow_rise) || ((state_q == ST_STEP) && step_rise);
    en_d      = 1'b0;
    pend_d    = pend_q;
    drop_d    = drop_q;

    if (state_q == ST_HALT) begin
      pend_d = 1'b0;
    end else if (pend_q) begin
      // The buffered pulse always wins; a colliding event is lost and flagged.
      if (event_hit) drop_d = 1'b1;
      if (!stall) begin
        en_d   = 1'b1;
        pend_d = 1'b0;
      end
    end else if (event_hit) begin
      if (stall) pend_d = 1'b1;
      else       en_d   = 1'b1;
    end

    cnt_d = cnt_q;
`ifdef STEP_CTRL_CNT_SAT_EN
    if (en_q && (cnt_q != '1)) cnt_d = cnt_q + CNT_ONE;
`else
    if (en_q) cnt_d = cnt_q + CNT_ONE;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= ST_HALT;
      en_q    <= 1'b0;
      pend_q  <= 1'b0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
    end
  end

  assign en_out    = en_q;
  assign pending   = pend_q;
  assign dropped   = drop_q;
  assign pulse_cnt = cnt_q;

endmodule
